// File: rtl/score_browser_if.sv
// Bus bundle between the view mux / score store and the score browser.
interface score_browser_if #(
  parameter int MAX_PLAYERS = 8,
  parameter int SCORE_W     = 10
);
  logic [2:0]                     view;
  logic [4:0]                     bt_edge;
  logic [3:0]                     player_count;
  logic [MAX_PLAYERS*SCORE_W-1:0] scores;
  logic [63:0]                    disp;
  logic [23:0]                    led;
  logic                           buzzer;

  modport master (
    output view, bt_edge, player_count, scores,
    input  disp, led, buzzer
  );

  modport slave (
    input  view, bt_edge, player_count, scores,
    output disp, led, buzzer
  );
endinterface

// File: rtl/score_browser.sv
// Player-score browser for the inspect view: selection, auto-scroll, leader
// flags, navigation beep and an 8-digit active-low segment display.
module score_browser #(
  parameter int         MAX_PLAYERS = 8,
  parameter int         SCORE_W     = 10,
  parameter logic [2:0] VIEW_ID     = 3'd3,
  parameter int         AUTO_PERIOD = 100_000_000,
  parameter int         BEEP_CYCLES = 10_000_000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  score_browser_if.slave bus
);
  localparam int TIMER_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int BEEP_W  = $clog2(BEEP_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_PERIOD - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LOAD  = BEEP_W'(BEEP_CYCLES);
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_L     = 8'hC7;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  logic [3:0]         sel_q, sel_d;
  logic               auto_q, auto_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [BEEP_W-1:0]  beep_q, beep_d;
  logic [63:0]        disp_q, disp_d;
  logic [23:0]        led_q, led_d;
  logic               buzzer_q, buzzer_d;

  logic                   active;
  logic [3:0]             n;
  logic [3:0]             sel_inc, sel_dec;
  logic [SCORE_W-1:0]     score [MAX_PLAYERS];
  logic [SCORE_W-1:0]     max_score;
  logic [MAX_PLAYERS-1:0] leader;
  logic [SCORE_W-1:0]     cur_score;
  logic                   cur_lead;
  int                     s_val, hund, tens, ones;
  logic                   unused_bt;

  assign unused_bt = ^bus.bt_edge[4:3];
  assign active    = (bus.view == VIEW_ID);

  always_comb begin
    if (bus.player_count == 4'd0)
      n = 4'd1;
    else if (int'(bus.player_count) > MAX_PLAYERS)
      n = 4'(MAX_PLAYERS);
    else
      n = bus.player_count;
  end

  // Leader search covers only the n active slots.
  always_comb begin
    max_score = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      score[i] = bus.scores[i*SCORE_W +: SCORE_W];
      if (i < int'(n) && score[i] > max_score)
        max_score = score[i];
    end
    for (int i = 0; i < MAX_PLAYERS; i++)
      leader[i] = (i < int'(n)) && (score[i] == max_score) && (max_score != '0);
  end

  always_comb begin
    sel_dec = (sel_q == 4'd1) ? n : sel_q - 4'd1;
    sel_inc = (sel_q == n) ? 4'd1 : sel_q + 4'd1;
    sel_d   = sel_q;
    auto_d  = auto_q;
    timer_d = timer_q;
    if (auto_q)
      timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + TIMER_W'(1);

    if (!active) begin
      sel_d   = 4'd1;
      auto_d  = 1'b0;
      timer_d = '0;
    end else if (sel_q > n) begin
      sel_d = n;
    end else if (bus.bt_edge[1]) begin
      sel_d   = sel_dec;
      timer_d = '0;
    end else if (bus.bt_edge[0]) begin
      sel_d   = sel_inc;
      timer_d = '0;
    end else if (bus.bt_edge[2]) begin
      auto_d  = ~auto_q;
      timer_d = '0;
    end else if (auto_q && timer_q == TIMER_LAST) begin
      sel_d = sel_inc;
    end

    // A wrap that lands on the same player is not a change and stays silent.
    if (!active)
      beep_d = '0;
    else if (sel_d != sel_q)
      beep_d = BEEP_LOAD;
    else if (beep_q != '0)
      beep_d = beep_q - BEEP_W'(1);
    else
      beep_d = '0;
  end

  always_comb begin
    cur_score = '0;
    cur_lead  = 1'b0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if (i == int'(sel_q) - 1) begin
        cur_score = score[i];
        cur_lead  = leader[i];
      end
    end
    s_val = (int'(cur_score) > 999) ? 999 : int'(cur_score);
    hund  = s_val / 100;
    tens  = (s_val / 10) % 10;
    ones  = s_val % 10;

    disp_d = {seg_of(4'(ones)),
              (hund == 0 && tens == 0) ? SEG_BLANK : seg_of(4'(tens)),
              (hund == 0) ? SEG_BLANK : seg_of(4'(hund)),
              cur_lead ? SEG_L : SEG_BLANK,
              SEG_BLANK,
              seg_of(sel_q % 4'd10),
              (sel_q >= 4'd10) ? seg_of(4'd1) : SEG_BLANK,
              SEG_P};
    led_d    = {auto_q, {(23-MAX_PLAYERS){1'b0}}, leader};
    buzzer_d = (beep_q != '0);

    if (!active) begin
      disp_d   = '1;
      led_d    = '0;
      buzzer_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q    <= 4'd1;
      auto_q   <= 1'b0;
      timer_q  <= '0;
      beep_q   <= '0;
      disp_q   <= '1;
      led_q    <= '0;
      buzzer_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      auto_q   <= auto_d;
      timer_q  <= timer_d;
      beep_q   <= beep_d;
      disp_q   <= disp_d;
      led_q    <= led_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign bus.disp   = disp_q;
  assign bus.led    = led_q;
  assign bus.buzzer = buzzer_q;
endmodule
